// File: rtl/rs_shift_iter_pkg.sv
// Shared types and constants for the iterative right shifter: FSM state encodings and step selects.
// The state encodings are fixed because stall control decodes them as well.
package rs_shift_iter_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_SHIFT = 2'd1,
        RS_DONE  = 2'd2
    } rs_state_t;

    typedef enum logic [1:0] {
        STEP_1  = 2'd0,
        STEP_4  = 2'd1,
        STEP_16 = 2'd2
    } step_sel_t;

    function automatic logic [SHW-1:0] step_amt(input step_sel_t sel);
        case (sel)
            STEP_4:  return 5'd4;
            STEP_16: return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/rs_shift_iter_if.sv
// Request/response bundle between the ALU multicycle issue logic (master) and the shifter (slave).
interface rs_shift_iter_if
    import rs_shift_iter_pkg::*;
    ();

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, data_in, shamt, arith,
        input  result, busy, done
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output result, busy, done
    );

endinterface

// File: rtl/rs_shift_step.sv
// One combinational right-shift step by a fixed amount (1, 4 or 16) with a supplied fill bit.
module rs_shift_step
    import rs_shift_iter_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    input  step_sel_t        sel,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = {fill, din[WIDTH-1:1]};
        case (sel)
            STEP_4:  dout = {{4{fill}}, din[WIDTH-1:4]};
            STEP_16: dout = {{16{fill}}, din[WIDTH-1:16]};
            default: dout = {fill, din[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/rs_shift_iter.sv
// Iterative 32-bit SRL/SRA: steps by 4 while at least 4 remain, then by 1.
// Define RS_SHIFT16_EN to add a leading by-16 step (at most 7 steps instead of 10).
module rs_shift_iter
    import rs_shift_iter_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    rs_shift_iter_if.slave      bus
);

    rs_state_t        state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   rem_nxt;
    logic             fill;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] step_out;
    step_sel_t        sel;

    always_comb begin
        sel = STEP_1;
`ifdef RS_SHIFT16_EN
        if (rem >= 5'd16)
            sel = STEP_16;
        else if (rem >= 5'd4)
            sel = STEP_4;
`else
        if (rem >= 5'd4)
            sel = STEP_4;
`endif
        rem_nxt = rem - step_amt(sel);
    end

    rs_shift_step u_step (
        .din  (acc),
        .fill (fill),
        .sel  (sel),
        .dout (step_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            RS_IDLE: begin
                if (bus.start)
                    state_nxt = (bus.shamt == '0) ? RS_DONE : RS_SHIFT;
            end
            RS_SHIFT: begin
                if (rem_nxt == '0)
                    state_nxt = RS_DONE;
            end
            RS_DONE:  state_nxt = RS_IDLE;
            default:  state_nxt = RS_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= RS_IDLE;
        else
            state <= state_nxt;
    end

    // result only changes on the edge that enters DONE, so it holds across the next operation
    always_ff @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            rem      <= '0;
            fill     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (bus.start) begin
                        acc  <= bus.data_in;
                        rem  <= bus.shamt;
                        fill <= bus.arith & bus.data_in[WIDTH-1];
                        if (bus.shamt == '0)
                            result_q <= bus.data_in;
                    end
                end
                RS_SHIFT: begin
                    acc <= step_out;
                    rem <= rem_nxt;
                    if (rem_nxt == '0)
                        result_q <= step_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state != RS_IDLE);
    assign bus.done   = (state == RS_DONE);

endmodule

// File: tb/tb_rs_shift_iter.sv
// Directed and randomized checks of rs_shift_iter: results, latency, handshake and reset abort.
module tb_rs_shift_iter;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] last_exp;

    rs_shift_iter_if bus ();

    rs_shift_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    function automatic int exp_steps(input int s);
`ifdef RS_SHIFT16_EN
        return s / 16 + (s % 16) / 4 + s % 4;
`else
        return s / 4 + s % 4;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          input logic [31:0] exp, input string name);
        int lat;
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.shamt   = s;
        bus.arith   = a;
        @(negedge clock);
        bus.start   = 1'b0;
        bus.data_in = $urandom;
        bus.shamt   = 5'($urandom);
        bus.arith   = 1'($urandom);
        lat = 1;
        chk({name, " busy"}, {31'd0, bus.busy}, 32'd1);
        if (s != 0)
            chk({name, " hold"}, bus.result, last_exp);
        while (!bus.done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk({name, " latency"}, lat, exp_steps(s) + 1);
        chk({name, " result"}, bus.result, exp);
        @(negedge clock);
        chk({name, " done pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        last_exp = exp;
    endtask

    initial begin
        int ndone;
        int lat;
        logic [31:0] rd;
        logic [4:0]  rs;
        logic        ra;
        logic signed [31:0] sd;
        logic [31:0] rexp;

        checks = 0;
        errors = 0;
        last_exp = 32'd0;

        vecs[0]  = '{32'hF000_0000, 5'd5,  1'b0, 32'h0780_0000};
        vecs[1]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[3]  = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
        vecs[4]  = '{32'h7FFF_FFFF, 5'd8,  1'b1, 32'h007F_FFFF};
        vecs[5]  = '{32'hDEAD_BEEF, 5'd4,  1'b0, 32'h0DEA_DBEE};
        vecs[6]  = '{32'hDEAD_BEEF, 5'd4,  1'b1, 32'hFDEA_DBEE};
        vecs[7]  = '{32'h8000_0000, 5'd1,  1'b1, 32'hC000_0000};
        vecs[8]  = '{32'h0000_FFFF, 5'd16, 1'b1, 32'h0000_0000};
        vecs[9]  = '{32'hFFFF_0000, 5'd3,  1'b1, 32'hFFFF_E000};
        vecs[10] = '{32'hA5A5_A5A5, 5'd7,  1'b0, 32'h014B_4B4B};

        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 5'd3;
        bus.arith   = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset state", {bus.result[31:2], bus.done, bus.busy} | {30'd0, bus.result[1:0]}, 32'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("idle after reset", {30'd0, bus.done, bus.busy}, 32'd0);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));

        // start held high and inputs churning while busy: exactly one operation runs
        bus.start   = 1'b1;
        bus.data_in = 32'h7FFF_FFFF;
        bus.shamt   = 5'd8;
        bus.arith   = 1'b1;
        ndone = 0;
        lat = 0;
        while (ndone == 0 && lat < 40) begin
            @(negedge clock);
            lat++;
            if (bus.done) begin
                ndone++;
                bus.start = 1'b0;
            end else begin
                bus.data_in = $urandom;
                bus.shamt   = 5'($urandom);
                bus.arith   = 1'($urandom);
            end
        end
        chk("busy starts latency", lat, exp_steps(8) + 1);
        chk("busy starts result", bus.result, 32'h007F_FFFF);
        repeat (12) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        chk("busy starts single done", ndone, 1);
        last_exp = 32'h007F_FFFF;

        // reset mid-shift aborts with no done pulse
        bus.start   = 1'b1;
        bus.data_in = 32'h8000_0000;
        bus.shamt   = 5'd31;
        bus.arith   = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort busy/done", {30'd0, bus.done, bus.busy}, 32'd0);
        chk("abort result", bus.result, 32'd0);
        reset = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort no later done", ndone, 0);
        last_exp = 32'd0;

        for (int i = 0; i < 300; i++) begin
            rd = $urandom;
            rs = 5'($urandom);
            ra = 1'($urandom);
            sd = rd;
            rexp = ra ? 32'(sd >>> rs) : (rd >> rs);
            run_op(rd, rs, ra, rexp, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
